adder_seq_ctrl: RTL and testbench

- Multi-precision add/subtract sequencer built around the team's shared 8-bit carry-propagate adder (A, B, Cin in; SUM, Cout out).
- Accepts NBYTES-wide operands over a valid/ready handshake and feeds them to the external adder one byte per cycle, LSB first, chaining the carry through a register.
- Returns the full-width result and flags on a second valid/ready handshake.
- Sits between the host/register interface and the single adder instance; it is the only block that drives that adder.

---
 rtl/adder_seq_ctrl_if.sv | 34 +++
 rtl/adder_seq_ctrl.sv | 113 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/adder_seq_ctrl_if.sv
// Request/response handshake bundle for the multi-precision add/sub sequencer.
// Host side is master, sequencer side is slave.
interface adder_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Byte-serial add/sub sequencer driving a shared external 8-bit adder,
// LSB first, with the carry chained through a register.
module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_seq_ctrl_if.slave       bus,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  busy
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  res_q;
  logic          cout_q;
  logic          ovf_q;
  logic          in_ready;
  logic          out_valid;
  logic          accept;
  logic          last;

  assign accept = bus.in_valid & in_ready;
  assign last   = (idx_q == IW'(NBYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = a_q[{idx_q, 3'b000} +: 8];
        add_b   = b_q[{idx_q, 3'b000} +: 8];
        add_cin = carry_q;
        busy    = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // B is stored already inverted for subtract, so the adder only ever adds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= bus.in_sub ? 1'b1 : bus.in_cin;
      a_q     <= bus.in_a;
      b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      res_q   <= '0;
    end else if (state_q == RUN) begin
      res_q[{idx_q, 3'b000} +: 8] <= add_sum;
      carry_q <= add_cout;
      idx_q   <= idx_q + IW'(1);
      if (last) begin
        cout_q <= add_cout;
        ovf_q  <= (a_q[W-1] ^ add_sum[7]) & (b_q[W-1] ^ add_sum[7]);
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_ovf    = ovf_q;
  assign bus.out_zero   = out_valid & (res_q == '0);
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl with a behavioural 8-bit adder
// standing in for the shared adder instance.
module tb_adder_seq_ctrl;
  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic       clk;
  logic       rst;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_cin;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       busy;
  int         errs;
  int         nchk;

  adder_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();

  adder_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b}
                             + {8'b0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Call #1 after a rising edge with the DUT idle.
  task automatic run_op(input string tag,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin,
                        input logic hold, input int backp,
                        input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic ez);
    int cyc;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) bus.in_a = '1;
    else      bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      if (hold) chk({tag, ".run_rdy"}, 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".lat"}, 64'(cyc), 64'(NBYTES + 1));
    for (int i = 0; i < backp; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".bp_v"}, 64'(bus.out_valid), 64'd1);
      chk({tag, ".bp_r"}, 64'(bus.out_result), 64'(er));
    end
    chk({tag, ".res"},  64'(bus.out_result), 64'(er));
    chk({tag, ".cout"}, 64'(bus.out_cout), 64'(ec));
    chk({tag, ".ovf"},  64'(bus.out_ovf), 64'(eo));
    chk({tag, ".zero"}, 64'(bus.out_zero), 64'(ez));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".post"}, {bus.out_valid, bus.in_ready, busy}, 64'b010);
    chk({tag, ".held"}, 64'(bus.out_result), 64'(er));
  endtask

  initial begin
    errs          = 0;
    nchk          = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.hs", {bus.in_ready, bus.out_valid, busy}, 64'b100);
    chk("rst.out", {bus.out_result, bus.out_cout, bus.out_ovf,
                    bus.out_zero}, 64'd0);
    chk("rst.add", {add_a, add_b, add_cin}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("ripple", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b0, 0,
           32'h00000100, 1'b0, 1'b0, 1'b0);
    run_op("wrap", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 0,
           32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sub57", 32'd5, 32'd7, 1'b1, 1'b0, 1'b0, 0,
           32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub75", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, 0,
           32'h00000002, 1'b1, 1'b0, 1'b0);
    run_op("ovfadd", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 0,
           32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("ovfsub", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 0,
           32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    run_op("hold", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, 6,
           32'h23456789, 1'b0, 1'b0, 1'b0);
    chk("hold.idle", 64'(busy), 64'd0);
    run_op("b2b", 32'h00000003, 32'h00000004, 1'b0, 1'b1, 1'b0, 0,
           32'h00000008, 1'b0, 1'b0, 1'b0);

    bus.in_a     = 32'h11223344;
    bus.in_b     = 32'h55667788;
    bus.in_sub   = 1'b0;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.idx2", 64'(add_a), 64'h22);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.hs", {bus.in_ready, bus.out_valid, busy}, 64'b100);
    chk("abort.add", {add_a, add_b, add_cin}, 64'd0);
    chk("abort.out", {bus.out_result, bus.out_cout, bus.out_ovf,
                      bus.out_zero}, 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("after", 32'h00000010, 32'h00000020, 1'b0, 1'b0, 1'b0, 0,
           32'h00000030, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
